// File: rtl/data_mem_port_pkg.sv
// Shared types and constants for the memory-stage data port.
package mem_port_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_AW = 8;

    // Load result substituted when a read is abandoned; sliced to DW by users.
    localparam logic [63:0] TIMEOUT_FILL = '1;

endpackage

// File: rtl/data_mem_port_access_timer.sv
// Wait-cycle counter for an outstanding memory request; flags the last allowed cycle.
module access_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_port.sv
// Memory-stage load/store port: issues one handshaked access per instruction and stalls the core meanwhile.
module data_mem_port
    import mem_port_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [AW-1:0] Addr,
    input  logic [DW-1:0] StoreData,
    output logic          Stall,
    output logic [DW-1:0] DataMemOut,
    output logic          LoadValid,
    output logic          Err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    state_t state;
    logic   start;
    logic   expired;

    assign start = (state == IDLE) && (MemRead || MemWrite);
    assign Stall = start || (state == REQ);

    access_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (Clk),
        .rst    (Reset),
        .clear  (start),
        .enable (state == REQ),
        .expired(expired)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            DataMemOut <= '0;
            LoadValid  <= 1'b0;
            Err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    LoadValid <= 1'b0;
                    if (start) begin
                        mem_addr  <= Addr;
                        mem_wdata <= StoreData;
                        mem_we    <= MemWrite;
                        mem_req   <= 1'b1;
                        state     <= REQ;
                        if (MemRead && MemWrite) begin
                            Err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle still counts as success.
                    if (mem_ack || expired) begin
                        mem_req   <= 1'b0;
                        state     <= DONE;
                        LoadValid <= !mem_we;
                        if (!mem_we) begin
                            DataMemOut <= mem_ack ? mem_rdata : TIMEOUT_FILL[DW-1:0];
                        end
                        if (!mem_ack) begin
                            Err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    LoadValid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port with a transaction-level reference model and per-cycle compare.
module tb_data_mem_port;

    localparam int TO = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       MemRead = 1'b0;
    logic       MemWrite = 1'b0;
    logic [7:0] Addr = '0;
    logic [7:0] StoreData = '0;
    logic       Stall;
    logic [7:0] DataMemOut;
    logic       LoadValid;
    logic       Err;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    data_mem_port #(
        .DW(8),
        .AW(8),
        .TIMEOUT(TO)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .StoreData (StoreData),
        .Stall     (Stall),
        .DataMemOut(DataMemOut),
        .LoadValid (LoadValid),
        .Err       (Err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 Clk = ~Clk;

    // Memory responder: acks after ack_delay request cycles; rdata is garbage outside the ack cycle.
    int         ack_delay = 0;
    logic [7:0] rdata_val = '0;
    int         rsp_cnt = 0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) rsp_cnt <= 0;
        else       rsp_cnt <= mem_req ? rsp_cnt + 1 : 0;
    end

    assign mem_ack   = mem_req && (rsp_cnt == ack_delay);
    assign mem_rdata = mem_ack ? rdata_val : ~rdata_val;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted access occupies a known number of request cycles, then one done cycle.
    int         m_left = 0;
    bit         m_done = 0;
    bit         m_isrd = 0;
    bit         m_acked = 0;
    bit         m_we = 0;
    bit         m_lv = 0;
    bit         m_err = 0;
    logic [7:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    logic [7:0] m_dout = '0;

    initial begin
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) begin
                m_left = 0; m_done = 0; m_isrd = 0; m_acked = 0; m_we = 0;
                m_lv = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_dout = '0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_lv   = m_isrd;
                    if (m_isrd) m_dout = m_acked ? rdata_val : 8'hFF;
                    if (!m_acked) m_err = 1;
                end
            end else if (m_done) begin
                m_done = 0;
                m_lv   = 0;
            end else begin
                m_lv = 0;
                if (MemRead || MemWrite) begin
                    m_addr  = Addr;
                    m_wdata = StoreData;
                    m_we    = MemWrite;
                    m_isrd  = !MemWrite;
                    if (MemRead && MemWrite) m_err = 1;
                    m_acked = (ack_delay < TO);
                    m_left  = m_acked ? ack_delay + 1 : TO;
                end
            end
        end
    end

    initial begin
        logic exp_stall;
        forever begin
            @(negedge Clk);
            exp_stall = (m_left > 0) || (m_left == 0 && !m_done && (MemRead || MemWrite));
            chk("stall",      Stall,      exp_stall);
            chk("mem_req",    mem_req,    m_left > 0);
            chk("mem_we",     mem_we,     m_we);
            chk("mem_addr",   mem_addr,   m_addr);
            chk("mem_wdata",  mem_wdata,  m_wdata);
            chk("dmem_out",   DataMemOut, m_dout);
            chk("load_valid", LoadValid,  m_lv);
            chk("err",        Err,        m_err);
        end
    end

    int   req_rises = 0;
    logic req_prev = 1'b0;
    always @(negedge Clk) begin
        if (mem_req && !req_prev) req_rises++;
        req_prev = mem_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Drives one instruction and samples through its done cycle; returns just after that cycle's midpoint.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input int dly, input logic [7:0] rdat,
                          output int stalls, output int reqs, output int lvs,
                          output logic we_seen, output logic [7:0] dout);
        int n;
        n = (dly < TO) ? dly + 1 : TO;
        ack_delay = dly; rdata_val = rdat;
        MemRead = rd; MemWrite = wr; Addr = a; StoreData = d;
        stalls = 0; reqs = 0; lvs = 0; we_seen = 1'b0;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge Clk);
            stalls += int'(Stall);
            reqs   += int'(mem_req);
            lvs    += int'(LoadValid);
            if (mem_req) we_seen = we_seen | mem_we;
        end
        dout = DataMemOut;
        #1;
    endtask

    task automatic drop_inputs();
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        int         st, rq, lv, rises0, lv_sum;
        logic       we;
        logic [7:0] dout;

        @(negedge Clk);
        chk("rst_dout", DataMemOut, 8'h00);
        chk("rst_req",  mem_req,    1'b0);
        chk("rst_err",  Err,        1'b0);
        #2 Reset = 1'b0;
        @(negedge Clk); #1;

        // Store, ack in first request cycle
        access(1'b0, 1'b1, 8'h10, 8'hA5, 0, 8'h00, st, rq, lv, we, dout);
        drop_inputs();
        chk("st_stall_cycles", st, 2);
        chk("st_req_cycles",   rq, 1);
        chk("st_we",           we, 1'b1);
        chk("st_lv",           lv, 0);
        chk("st_dout",         dout, 8'h00);
        chk("st_addr",         mem_addr, 8'h10);
        chk("st_wdata",        mem_wdata, 8'hA5);

        // Load, ack after 3 wait cycles (coincides with the last allowed cycle)
        @(negedge Clk); #1;
        access(1'b1, 1'b0, 8'h22, 8'h00, 3, 8'h3C, st, rq, lv, we, dout);
        drop_inputs();
        chk("ld_stall_cycles", st, 5);
        chk("ld_lv",           lv, 1);
        chk("ld_dout",         dout, 8'h3C);
        chk("ld_err",          Err, 1'b0);

        // Back-to-back load then store, second instruction presented right after the done cycle
        @(negedge Clk); #1;
        rises0 = req_rises;
        access(1'b1, 1'b0, 8'h30, 8'h00, 1, 8'h77, st, rq, lv, we, dout);
        chk("b2b_ld_dout", dout, 8'h77);
        chk("b2b_ld_req",  rq, 2);
        access(1'b0, 1'b1, 8'h31, 8'h88, 0, 8'h00, st, rq, lv, we, dout);
        drop_inputs();
        chk("b2b_st_stall", st, 2);
        chk("b2b_st_dout",  dout, 8'h77);
        repeat (3) @(negedge Clk);
        #1;
        chk("b2b_req_count", req_rises - rises0, 2);

        // Load with no ack: timeout
        access(1'b1, 1'b0, 8'h44, 8'h00, 99, 8'h55, st, rq, lv, we, dout);
        drop_inputs();
        chk("to_req_cycles", rq, TO);
        chk("to_lv",         lv, 1);
        chk("to_dout",       dout, 8'hFF);
        repeat (3) @(negedge Clk);
        chk("to_err_sticky", Err, 1'b1);

        #1 Reset = 1'b1;
        @(negedge Clk); #1 Reset = 1'b0;
        @(negedge Clk); #1;

        // Simultaneous read and write
        access(1'b1, 1'b1, 8'h40, 8'h11, 0, 8'h00, st, rq, lv, we, dout);
        drop_inputs();
        chk("ill_req",  rq, 1);
        chk("ill_we",   we, 1'b1);
        chk("ill_lv",   lv, 0);
        chk("ill_err",  Err, 1'b1);
        chk("ill_addr", mem_addr, 8'h40);

        // Reset during a pending read
        @(negedge Clk); #1;
        ack_delay = 99; MemRead = 1'b1; Addr = 8'h50;
        @(negedge Clk);
        @(posedge Clk); #2;
        chk("rm_req_before", mem_req, 1'b1);
        Reset = 1'b1;
        #1;
        chk("rm_req_after", mem_req, 1'b0);
        chk("rm_lv",        LoadValid, 1'b0);
        chk("rm_dout",      DataMemOut, 8'h00);
        chk("rm_err",       Err, 1'b0);
        chk("rm_addr",      mem_addr, 8'h00);
        drop_inputs();
        @(negedge Clk); #1 Reset = 1'b0;
        lv_sum = 0;
        repeat (4) begin
            @(negedge Clk);
            lv_sum += int'(LoadValid);
        end
        chk("rm_no_lv", lv_sum, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
